// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: one requester's handshake and data bus into the RAM arbiter
interface ram_arbiter_if;
    logic        req;
    logic        we;
    logic        lock;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        ack;
    logic        err;
    logic [15:0] rdata;
    modport master (output req, we, lock, addr, wdata, input ack, err, rdata);
    modport slave  (input req, we, lock, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter for the single-port data RAM with bounded locked bursts
module ram_arbiter #(
    parameter int RAM_DEPTH = 256,
    parameter int MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    ram_arbiter_if.slave      p0,
    ram_arbiter_if.slave      p1,
    output logic              ram_control,
    output logic [15:0]       ram_address,
    output logic [15:0]       ram_write_data,
    input  logic [15:0]       ram_read_data
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [16:0] DEPTH = 17'(RAM_DEPTH);
    localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    state_t        state;
    state_t        state_n;
    logic          grant;
    logic          rr_last;
    logic          winner;
    logic          any_req;
    logic          req_g;
    logic          we_g;
    logic          lock_g;
    logic          in_range;
    logic          cont;
    logic [15:0]   addr_g;
    logic [15:0]   wdata_g;
    logic [15:0]   addr_q;
    logic [15:0]   wdata_q;
    logic [BW-1:0] burst_cnt;
    logic [1:0]    ack_q;
    logic [1:0]    err_q;
    logic [15:0]   rdata_q [2];

    // Winner selection, granted-requester mux and RAM drive; address/data hold outside ACCESS
    always_comb begin
        any_req        = p0.req | p1.req;
        winner         = (p0.req & p1.req) ? ~rr_last : p1.req;
        req_g          = grant ? p1.req   : p0.req;
        we_g           = grant ? p1.we    : p0.we;
        lock_g         = grant ? p1.lock  : p0.lock;
        addr_g         = grant ? p1.addr  : p0.addr;
        wdata_g        = grant ? p1.wdata : p0.wdata;
        in_range       = {1'b0, addr_g} < DEPTH;
        cont           = lock_g & req_g & (burst_cnt < BMAX);
        ram_control    = (state == ACCESS) & we_g & in_range;
        ram_address    = (state == ACCESS) ? addr_g  : addr_q;
        ram_write_data = (state == ACCESS) ? wdata_g : wdata_q;
    end

    // Next-state logic: IDLE -> ACCESS -> RESPOND -> (ACCESS on burst | IDLE)
    always_comb begin
        state_n = state;
        state_n = (state == IDLE)   ? (any_req ? ACCESS : IDLE) :
                  (state == ACCESS) ? RESPOND :
                  (cont ? ACCESS : IDLE);
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Grant bookkeeping, burst counting and registered responses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant      <= 1'b0;
            rr_last    <= 1'b1;
            burst_cnt  <= '0;
            ack_q      <= '0;
            err_q      <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            ack_q <= '0;
            if (state == IDLE && any_req) begin
                grant     <= winner;
                rr_last   <= winner;
                burst_cnt <= BW'(1);
            end
            if (state == RESPOND)
                burst_cnt <= cont ? burst_cnt + 1'b1 : '0;
            if (state == ACCESS) begin
                ack_q[grant]   <= 1'b1;
                err_q[grant]   <= ~in_range;
                rdata_q[grant] <= (in_range && !we_g) ? ram_read_data : 16'h0000;
                addr_q         <= addr_g;
                wdata_q        <= wdata_g;
            end
        end
    end

    assign p0.ack   = ack_q[0];
    assign p0.err   = err_q[0];
    assign p0.rdata = rdata_q[0];
    assign p1.ack   = ack_q[1];
    assign p1.err   = err_q[1];
    assign p1.rdata = rdata_q[1];
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter with a behavioural RAM
module tb_ram_arbiter;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ram_control;
    logic [15:0] ram_address;
    logic [15:0] ram_write_data;
    logic [15:0] ram_read_data;
    logic [15:0] mem [256];

    logic        req_d [2];
    logic        we_d [2];
    logic        lock_d [2];
    logic [15:0] addr_d [2];
    logic [15:0] wdata_d [2];
    logic        ack_w [2];
    logic        err_w [2];
    logic [15:0] rdata_w [2];

    typedef struct {
        int          id;
        logic [15:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int   n_chk = 0;
    int   n_fail = 0;
    int   wr_cycles = 0;
    int   lat0, lat1;
    logic prev_ack [2];

    ram_arbiter_if i0 ();
    ram_arbiter_if i1 ();

    assign i0.req = req_d[0];
    assign i0.we = we_d[0];
    assign i0.lock = lock_d[0];
    assign i0.addr = addr_d[0];
    assign i0.wdata = wdata_d[0];
    assign i1.req = req_d[1];
    assign i1.we = we_d[1];
    assign i1.lock = lock_d[1];
    assign i1.addr = addr_d[1];
    assign i1.wdata = wdata_d[1];
    assign ack_w[0] = i0.ack;
    assign ack_w[1] = i1.ack;
    assign err_w[0] = i0.err;
    assign err_w[1] = i1.err;
    assign rdata_w[0] = i0.rdata;
    assign rdata_w[1] = i1.rdata;

    ram_arbiter #(.RAM_DEPTH(256), .MAX_BURST(4)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .p0(i0.slave),
        .p1(i1.slave),
        .ram_control(ram_control),
        .ram_address(ram_address),
        .ram_write_data(ram_write_data),
        .ram_read_data(ram_read_data)
    );

    always #5 clock = ~clock;

    assign ram_read_data = (ram_address < 16'd256) ? mem[ram_address[7:0]] : 16'hDEAD;

    always @(posedge clock)
        if (ram_control)
            mem[ram_address[7:0]] <= ram_write_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input logic [15:0] d, input logic e);
        exp_q.push_back('{id, d, e});
    endtask

    // Present one access and hold it until ack; keep leaves req high for a following access
    task automatic do_acc(input int id, input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic lk, input logic keep, output int lat);
        int n;
        req_d[id] = 1'b1;
        we_d[id] = w;
        addr_d[id] = a;
        wdata_d[id] = d;
        lock_d[id] = lk;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!ack_w[id] && n < 20);
        if (!ack_w[id]) begin
            n_chk++;
            n_fail++;
            $display("FAIL ack_timeout: requester %0d got no ack within %0d cycles", id, n);
        end
        lat = n;
        if (!keep) begin
            req_d[id] = 1'b0;
            lock_d[id] = 1'b0;
            we_d[id] = 1'b0;
        end
    endtask

    // Monitor: pops the scoreboard on every ack and checks order, data and pulse shape
    always @(negedge clock) begin
        if (reset_n) begin
            if (ram_control) begin
                wr_cycles++;
                check("wr_addr_in_range", {31'd0, ram_address < 16'd256}, 1);
            end
            if (ack_w[0])
                check("ack_overlap", {31'd0, ack_w[1]}, 0);
            for (int id = 0; id < 2; id++) begin
                if (ack_w[id]) begin
                    check("ack_pulse", {31'd0, prev_ack[id]}, 0);
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_ack: requester %0d acked with none expected", id);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("ack_order", id, mon_e.id);
                        check("rdata", {16'd0, rdata_w[id]}, {16'd0, mon_e.rdata});
                        check("err", {31'd0, err_w[id]}, {31'd0, mon_e.err});
                    end
                end
            end
        end
        prev_ack[0] <= ack_w[0];
        prev_ack[1] <= ack_w[1];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        for (int i = 0; i < 2; i++) begin
            req_d[i] = 1'b0;
            we_d[i] = 1'b0;
            lock_d[i] = 1'b0;
            addr_d[i] = 16'h0;
            wdata_d[i] = 16'h0;
            prev_ack[i] = 1'b0;
        end
        for (int i = 0; i < 256; i++)
            mem[i] <= 16'h0;
        mem[8'h00] <= 16'h5A5A;
        mem[8'h10] <= 16'hBEEF;
        for (int k = 0; k < 3; k++) begin
            mem[8'h20 + k] <= 16'h2000 + 16'(k);
            mem[8'h30 + k] <= 16'h3000 + 16'(k);
        end
        for (int k = 0; k < 5; k++)
            mem[8'h40 + k] <= 16'h4000 + 16'(k);
        mem[8'h50] <= 16'h5050;

        repeat (2) @(negedge clock);
        check("rst_ack0", {31'd0, ack_w[0]}, 0);
        check("rst_ack1", {31'd0, ack_w[1]}, 0);
        check("rst_err0", {31'd0, err_w[0]}, 0);
        check("rst_rdata0", {16'd0, rdata_w[0]}, 0);
        check("rst_ram_control", {31'd0, ram_control}, 0);
        check("rst_ram_address", {16'd0, ram_address}, 0);
        check("rst_ram_write_data", {16'd0, ram_write_data}, 0);
        reset_n = 1'b1;
        @(negedge clock);

        w0 = wr_cycles;
        push(0, 16'hBEEF, 1'b0);
        do_acc(0, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, lat0);
        check("read_latency", lat0, 2);
        check("read_no_write", wr_cycles - w0, 0);
        repeat (2) @(negedge clock);

        w0 = wr_cycles;
        push(1, 16'h0000, 1'b0);
        do_acc(1, 1'b1, 16'h00FF, 16'h1234, 1'b0, 1'b0, lat1);
        check("write_cycles", wr_cycles - w0, 1);
        check("write_mem", {16'd0, mem[8'hFF]}, 32'h1234);
        @(negedge clock);
        push(1, 16'h1234, 1'b0);
        do_acc(1, 1'b0, 16'h00FF, 16'h0, 1'b0, 1'b0, lat1);
        repeat (2) @(negedge clock);

        for (int k = 0; k < 3; k++) begin
            push(0, 16'h2000 + 16'(k), 1'b0);
            push(1, 16'h3000 + 16'(k), 1'b0);
        end
        fork
            begin
                int l;
                for (int k = 0; k < 3; k++)
                    do_acc(0, 1'b0, 16'h0020 + 16'(k), 16'h0, 1'b0, k < 2, l);
            end
            begin
                int l;
                for (int k = 0; k < 3; k++)
                    do_acc(1, 1'b0, 16'h0030 + 16'(k), 16'h0, 1'b0, k < 2, l);
            end
        join
        repeat (2) @(negedge clock);

        for (int k = 0; k < 4; k++)
            push(0, 16'h4000 + 16'(k), 1'b0);
        push(1, 16'h5050, 1'b0);
        push(0, 16'h4004, 1'b0);
        fork
            begin
                int l;
                for (int k = 0; k < 5; k++) begin
                    do_acc(0, 1'b0, 16'h0040 + 16'(k), 16'h0, 1'b1, k < 4, l);
                    if (k >= 1 && k <= 3)
                        check("burst_spacing", l, 2);
                end
            end
            begin
                int l;
                repeat (2) @(negedge clock);
                do_acc(1, 1'b0, 16'h0050, 16'h0, 1'b0, 1'b0, l);
            end
        join
        repeat (2) @(negedge clock);

        w0 = wr_cycles;
        push(0, 16'h0000, 1'b1);
        do_acc(0, 1'b1, 16'h0100, 16'hAAAA, 1'b0, 1'b0, lat0);
        check("oor_no_write", wr_cycles - w0, 0);
        check("oor_mem0", {16'd0, mem[8'h00]}, 32'h5A5A);
        repeat (2) @(negedge clock);

        req_d[1] = 1'b1;
        we_d[1] = 1'b1;
        addr_d[1] = 16'h0060;
        wdata_d[1] = 16'h7777;
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_ram_control", {31'd0, ram_control}, 0);
        check("midrst_ram_address", {16'd0, ram_address}, 0);
        check("midrst_ram_write_data", {16'd0, ram_write_data}, 0);
        check("midrst_ack1", {31'd0, ack_w[1]}, 0);
        check("midrst_rdata1", {16'd0, rdata_w[1]}, 0);
        check("midrst_err0", {31'd0, err_w[0]}, 0);
        @(negedge clock);
        req_d[1] = 1'b0;
        we_d[1] = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        push(0, 16'hBEEF, 1'b0);
        push(1, 16'h1234, 1'b0);
        fork
            do_acc(0, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, lat0);
            do_acc(1, 1'b0, 16'h00FF, 16'h0, 1'b0, 1'b0, lat1);
        join
        check("post_reset_latency0", lat0, 2);
        repeat (3) @(negedge clock);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-port round-robin arbiter that shares the single-port NBBPU data RAM (16-bit words, combinational read, write on rising clock) between requester 0 (CPU data port) and requester 1 (loader/debug port). It sequences each access through a fixed 3-state machine. It drives the RAM's control, address and write_data lines and returns registered read data with a one-cycle ack. It supports bounded locked bursts and rejects out-of-range addresses without touching the RAM.

Parameters:
RAM_DEPTH, 256, number of valid 16-bit words; addresses >= RAM_DEPTH are errors
MAX_BURST, 4, max consecutive locked accesses granted to one requester before forced re-arbitration (>=1)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req0, req1  input  1  access request; held high with stable we/addr/wdata/lock until ackN
we0, we1  input  1  1 = write, 0 = read
addr0, addr1  input  16  word address
wdata0, wdata1  input  16  write data
lock0, lock1  input  1  request back-to-back access (burst) after current one
ack0, ack1  output  1  one-cycle completion pulse
err0, err1  output  1  valid with ackN; 1 = address out of range
rdata0, rdata1  output  16  read data, valid while ackN=1
ram_control  output  1  RAM write enable (control[0])
ram_address  output  16  RAM address
ram_write_data  output  16  RAM write data
ram_read_data  input  16  RAM combinational read data

Behaviour:
- Reset (async, reset_n=0): state=IDLE, grant=0, rr_last=1 (so req0 wins first tie), burst_cnt=0; all ack/err=0, rdata=0, ram_control=0, ram_address=0, ram_write_data=0.
- States: IDLE, ACCESS, RESPOND.
- IDLE: if no req -> stay. Else select winner: a single requester wins outright; if both, winner = requester != rr_last. Register grant=winner, rr_last=winner, burst_cnt=1 -> ACCESS.
- ACCESS (1 cycle): ram_address/ram_write_data combinationally muxed from granted requester; ram_control = we_g AND (addr_g < RAM_DEPTH). Rising edge at end: RAM write commits; rdata_g <= (in range and read) ? ram_read_data : 0; err_g <= out of range; -> RESPOND.
- Outside ACCESS: ram_control=0; ram_address/ram_write_data hold last granted values (no glitching to the other requester).
- RESPOND (1 cycle): ack_g=1, err_g valid, rdata_g valid; the other requester's ack=0. Next state:
  - If lock_g=1, req_g=1 and burst_cnt < MAX_BURST: -> ACCESS, same grant, burst_cnt+1. The requester presents its next addr/we/wdata during this RESPOND cycle.
  - Otherwise -> IDLE; burst_cnt=0.
  - Requester must drop req during RESPOND unless continuing a burst. A req still high in IDLE after a non-burst RESPOND is a new request.
- Latency: req high before edge E0 -> ACCESS in cycle after E0 -> ack cycle after E1 -> IDLE after E2. Non-burst throughput is 1 access per 3 cycles; burst throughput is 1 per 2 cycles.
- rdata/err for a requester hold their last value outside ack; only ack qualifies them.
- Fairness: when both requesters request continuously without lock, grants alternate strictly. A burst is capped at MAX_BURST, after which rr_last makes the other requester win if it is waiting.
- Out-of-range write: no RAM write, err=1, rdata=0, ack as normal.
- reset_n asserted mid-ACCESS: state forced to IDLE asynchronously and ram_control drops immediately. Whether the write completes is undefined (reset races the write edge); the requester sees no ack.
- req deasserted by requester during ACCESS: illegal. The arbiter completes the access with the latched grant and still pulses ack.

Test Plan:
- Single read: RAM[0x10]=0xBEEF, req0 read addr=0x0010 -> ram_control=0 throughout, ack0 exactly 2 cycles after grant edge, rdata0=0xBEEF, err0=0, ack1 never high.
- Write then read: req1 write addr=0x00FF wdata=0x1234, then read 0x00FF -> ram_control=1 only in the ACCESS cycle; read returns 0x1234 with ack1.
- Contention: req0 and req1 raised in the same cycle, both held, no lock, 6 accesses -> grants in order 0,1,0,1,0,1; each ack is a single-cycle pulse.
- Burst cap: lock0=1 and req0 continuous, req1 waiting, MAX_BURST=4 -> four ack0 pulses spaced 2 cycles apart, then req1 granted before a fifth req0 access.
- Out of range: req0 write addr=0x0100 wdata=0xAAAA -> ram_control stays 0, RAM[0x00] unchanged, ack0=1 with err0=1 and rdata0=0.
- Reset mid-access: reset_n low during ACCESS -> all outputs 0 in that cycle; after release, state is IDLE and req1+req0 together grant req0 first.
